// File: rtl/dadda_divider_32by16.sv
// Sequential unsigned restoring divider, 32-bit dividend by 16-bit divisor.
// One quotient bit per clock, valid/ready handshakes on both sides.
module dadda_divider_32by16 #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] P,
  input  logic [VW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          dbz,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic          load_r;
  logic [31:0]   p_r;
  logic [15:0]   b_r;
  logic [15:0]   rem_r;
  logic [15:0]   sh_r;
  logic [15:0]   quo_r;
  logic [3:0]    cnt_r;
  logic [15:0]   q_r;
  logic [15:0]   r_r;
  logic          dbz_r;
  logic          ovf_r;

  logic [16:0]   t_s;
  logic [16:0]   diff_s;
  logic          ge_s;
  logic [15:0]   nrem_s;

  // Trial subtraction; rem < B keeps T below 2B, so diff bit 16 is the borrow.
  always_comb begin
    t_s    = {rem_r, sh_r[15]};
    diff_s = t_s - {1'b0, b_r};
    ge_s   = ~diff_s[16];
    if (ge_s) begin
      nrem_s = diff_s[15:0];
    end else begin
      nrem_s = t_s[15:0];
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      load_r  <= 1'b0;
      p_r     <= 32'd0;
      b_r     <= 16'd0;
      rem_r   <= 16'd0;
      sh_r    <= 16'd0;
      quo_r   <= 16'd0;
      cnt_r   <= 4'd0;
      q_r     <= 16'd0;
      r_r     <= 16'd0;
      dbz_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            p_r     <= P;
            b_r     <= B;
            load_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            load_r  <= 1'b0;
          end
        end
        RUN: begin
          if (load_r) begin
            load_r <= 1'b0;
            if (b_r == 16'd0) begin
              q_r     <= 16'hFFFF;
              r_r     <= p_r[15:0];
              dbz_r   <= 1'b1;
              ovf_r   <= 1'b0;
              state_r <= DONE;
            end else if (p_r[31:16] >= b_r) begin
              q_r     <= 16'hFFFF;
              r_r     <= 16'hFFFF;
              dbz_r   <= 1'b0;
              ovf_r   <= 1'b1;
              state_r <= DONE;
            end else begin
              rem_r <= p_r[31:16];
              sh_r  <= p_r[15:0];
              quo_r <= 16'd0;
              cnt_r <= 4'd15;
            end
          end else begin
            rem_r <= nrem_s;
            sh_r  <= {sh_r[14:0], 1'b0};
            quo_r <= {quo_r[14:0], ge_s};
            if (cnt_r == 4'd0) begin
              q_r     <= {quo_r[14:0], ge_s};
              r_r     <= nrem_s;
              dbz_r   <= 1'b0;
              ovf_r   <= 1'b0;
              state_r <= DONE;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          load_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign Q         = q_r;
  assign R         = r_r;
  assign dbz       = dbz_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_dadda_divider_32by16.sv
// Self-checking bench for dadda_divider_32by16: directed cases plus
// randomized operations against an arithmetic reference model.
module tb_dadda_divider_32by16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] P;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [15:0] R;
  logic        dbz;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  dadda_divider_32by16 #(.DW(32), .VW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {Q, R, dbz, ovf} from plain unsigned arithmetic.
  function automatic logic [33:0] ref_div(input logic [31:0] p, input logic [15:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 16'd0) begin
      return {16'hFFFF, p[15:0], 1'b1, 1'b0};
    end
    q = p / {16'd0, b};
    r = p % {16'd0, b};
    if (q > 32'h0000_FFFF) begin
      return {16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
    end
    return {q[15:0], r[15:0], 1'b0, 1'b0};
  endfunction

  // One full operation; entered and left at 1 time unit after a rising edge in IDLE.
  task automatic do_op(input logic [31:0] p, input logic [15:0] b,
                       input int stall, input bit pulse);
    logic [33:0] e;
    logic [31:0] qr;
    int lat;
    int exp_lat;
    e       = ref_div(p, b);
    exp_lat = (e[1] || e[0]) ? 1 : 17;
    P = p;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    P = $urandom;
    B = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("in_ready_busy", {63'd0, in_ready}, 64'd0);
    check("Q", {48'd0, Q}, {48'd0, e[33:18]});
    check("R", {48'd0, R}, {48'd0, e[17:2]});
    check("dbz", {63'd0, dbz}, {63'd0, e[1]});
    check("ovf", {63'd0, ovf}, {63'd0, e[0]});
    qr = {Q, R};
    for (int i = 0; i < stall; i++) begin
      if (pulse && i == 3) begin
        in_valid = 1'b1;
        P = 32'd55;
        B = 16'd5;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (pulse) begin
        check("hold_QR", {32'd0, Q, R}, {32'd0, qr});
        check("hold_flags", {61'd0, out_valid, in_ready, dbz}, {61'd0, 1'b1, 1'b0, e[1]});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("released", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] rp;
    logic [15:0] rb;
    bit quiet;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    P = 32'd0;
    B = 16'd0;
    #23;
    check("rst_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("rst_QR", {32'd0, Q, R}, 64'd0);
    check("rst_flags", {62'd0, dbz, ovf}, 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'd1000, 16'd7, 0, 1'b0);
    do_op(32'hFFFE_0001, 16'hFFFF, 0, 1'b0);
    do_op(32'h0000_FFFF, 16'd1, 0, 1'b0);
    do_op(32'h1234_5678, 16'd0, 0, 1'b0);
    do_op(32'h0001_0000, 16'd1, 0, 1'b0);
    do_op(32'h0000_FFFF, 16'h0001, 2, 1'b0);
    do_op(32'd123456, 16'd1000, 10, 1'b1);
    do_op(32'hDEAD_BEEF, 16'hDEAE, 0, 1'b0);

    // Asynchronous reset during iteration 8.
    P = 32'd1000;
    B = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("midrst_QR", {32'd0, Q, R}, 64'd0);
    check("midrst_flags", {62'd0, dbz, ovf}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    quiet = 1'b1;
    out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 1'b0;
    end
    out_ready = 1'b0;
    check("no_result_after_rst", {63'd0, quiet}, 64'd1);
    do_op(32'd100, 16'd9, 0, 1'b0);

    for (int k = 0; k < 2000; k++) begin
      rb = 16'($urandom_range(1, 65535));
      if (k % 8 == 0) rb = 16'($urandom_range(1, 15));
      rp = $urandom;
      if (k % 2 == 0) rp[31:16] = 16'($urandom % {16'd0, rb});
      do_op(rp, rb, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
